timer_ctrl: RTL and testbench

- Control stage directly around the generic up-counter (WIDTH bits, clear_i priority over enable_i, count_o registered).
- Drives the counter's clear and enable inputs and consumes its registered count output.
- Adds start/stop sequencing, a programmable prescaler, period-match detection, and one-shot or periodic modes.
- Feeds interrupt/event logic with a single-cycle tick and a sticky done flag.

---
 rtl/timer_pkg.sv | 14 +
 rtl/timer_ctrl.sv | 98 +++++++++
 tb/tb_timer_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the timer control stage.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_ctrl.sv
// Start/stop sequencing, prescaler and period-match control around an external up-counter.
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned PRE_W = 8
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             mode_i,
   input  logic [WIDTH-1:0] period_i,
   input  logic [PRE_W-1:0] prescale_i,
   input  logic [WIDTH-1:0] count_i,
   output logic             cnt_clear_o,
   output logic             cnt_enable_o,
   output logic             tick_o,
   output logic             busy_o,
   output logic             done_o
);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_period;
   logic [PRE_W-1:0] r_prescale;
   logic [PRE_W-1:0] r_pres;
   logic             r_mode;
   logic             w_pres_hit;
   logic             w_load;
   logic             w_run_step;

   always_comb begin
      w_next       = r_state;
      cnt_clear_o  = 1'b0;
      cnt_enable_o = 1'b0;
      tick_o       = 1'b0;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      w_run_step   = 1'b0;
      w_pres_hit   = (r_pres == r_prescale);
      // stop_i outranks start_i everywhere, so a combined request never loads config
      w_load       = start_i && !stop_i;
      case (r_state)
         IDLE: begin
            if (w_load) w_next = ARM;
         end
         ARM: begin
            cnt_clear_o = 1'b1;
            busy_o      = 1'b1;
            if (stop_i)       w_next = IDLE;
            else if (start_i) w_next = ARM;
            else              w_next = RUN;
         end
         RUN: begin
            busy_o = 1'b1;
            if (stop_i)       w_next = IDLE;
            else if (start_i) w_next = ARM;
            else begin
               w_run_step   = 1'b1;
               cnt_enable_o = w_pres_hit;
               if (w_pres_hit && (count_i == r_period)) begin
                  tick_o      = 1'b1;
                  cnt_clear_o = 1'b1;
                  if (r_mode == MODE_ONESHOT) w_next = DONE;
               end
            end
         end
         DONE: begin
            done_o = 1'b1;
            if (stop_i)       w_next = IDLE;
            else if (start_i) w_next = ARM;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state    <= IDLE;
         r_pres     <= '0;
         r_period   <= '0;
         r_prescale <= '0;
         r_mode     <= MODE_PERIODIC;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_period   <= period_i;
            r_prescale <= prescale_i;
            r_mode     <= mode_i;
            r_pres     <= '0;
         end else if (w_run_step) begin
            r_pres <= w_pres_hit ? '0 : r_pres + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural up-counter closing the loop.
module tb_timer_ctrl;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        start_i = 1'b0;
   logic        stop_i = 1'b0;
   logic        mode_i = 1'b0;
   logic [15:0] period_i = '0;
   logic [7:0]  prescale_i = '0;
   logic [15:0] count_i;
   logic        cnt_clear_o, cnt_enable_o, tick_o, busy_o, done_o;

   int total = 0;
   int bad   = 0;

   timer_ctrl #(.WIDTH(16), .PRE_W(8)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i),
      .mode_i(mode_i), .period_i(period_i), .prescale_i(prescale_i),
      .count_i(count_i), .cnt_clear_o(cnt_clear_o), .cnt_enable_o(cnt_enable_o),
      .tick_o(tick_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   // reference counter: clear wins over enable
   always @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)          count_i <= '0;
      else if (cnt_clear_o) count_i <= '0;
      else if (cnt_enable_o) count_i <= count_i + 16'd1;
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic go(input logic m, input logic [15:0] p, input logic [7:0] ps);
      mode_i = m; period_i = p; prescale_i = ps; start_i = 1'b1;
      step();
      start_i = 1'b0;
      period_i = 16'hDEAD; prescale_i = 8'h5A; mode_i = ~m;
   endtask

   initial begin
      int first;

      #2;
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_clr",  cnt_clear_o, 0);
      chk("rst_en",   cnt_enable_o, 0);
      chk("rst_tick", tick_o, 0);
      rstn_i = 1'b1;
      step();

      // periodic, period=3, prescale=0
      go(1'b0, 16'd3, 8'd0);
      chk("arm_clr", cnt_clear_o, 1);
      chk("arm_busy", busy_o, 1);
      chk("arm_en", cnt_enable_o, 0);
      step();
      for (int k = 0; k < 12; k++) begin
         chk("per_cnt", count_i, k % 4);
         chk("per_tick", tick_o, (k % 4) == 3);
         chk("per_en", cnt_enable_o, 1);
         step();
      end

      // one-shot, period=2, prescale=1 (restart from RUN)
      go(1'b1, 16'd2, 8'd1);
      chk("os_arm_clr", cnt_clear_o, 1);
      step();
      for (int k = 0; k < 6; k++) begin
         chk("os_tick", tick_o, k == 5);
         chk("os_en", cnt_enable_o, k % 2);
         step();
      end
      for (int k = 0; k < 3; k++) begin
         chk("os_done", done_o, 1);
         chk("os_busy", busy_o, 0);
         chk("os_clr", cnt_clear_o, 0);
         chk("os_en_d", cnt_enable_o, 0);
         chk("os_cnt", count_i, 0);
         step();
      end

      // restart out of DONE: done drops in ARM
      go(1'b0, 16'd5, 8'd0);
      chk("done_drop", done_o, 0);
      chk("done_arm", busy_o, 1);
      step();
      step();
      step();
      chk("stop_pre_cnt", count_i, 2);
      stop_i = 1'b1;
      #1;
      chk("stop_en", cnt_enable_o, 0);
      chk("stop_tick", tick_o, 0);
      step();
      stop_i = 1'b0;
      chk("stop_busy", busy_o, 0);
      step();
      chk("stop_cnt", count_i, 2);

      // stop+start together in RUN -> IDLE, count retained
      go(1'b0, 16'd5, 8'd0);
      step();
      step();
      start_i = 1'b1; stop_i = 1'b1;
      step();
      start_i = 1'b0; stop_i = 1'b0;
      chk("ss_busy", busy_o, 0);
      chk("ss_cnt", count_i, 1);
      step();
      chk("ss_idle", busy_o, 0);

      // restart at the match point suppresses the tick
      go(1'b0, 16'd3, 8'd0);
      step();
      step(); step(); step();
      chk("rs_cnt3", count_i, 3);
      period_i = 16'd1; prescale_i = 8'd0; mode_i = 1'b0; start_i = 1'b1;
      #1;
      chk("rs_tick", tick_o, 0);
      step();
      start_i = 1'b0;
      chk("rs_arm_clr", cnt_clear_o, 1);
      step();
      for (int k = 0; k < 6; k++) begin
         chk("rs_tick2", tick_o, k % 2);
         step();
      end

      // period=0, prescale=0: tick every RUN cycle
      go(1'b0, 16'd0, 8'd0);
      step();
      for (int k = 0; k < 4; k++) begin
         chk("p0_tick", tick_o, 1);
         chk("p0_cnt", count_i, 0);
         step();
      end

      // period max
      go(1'b0, 16'hFFFF, 8'd0);
      step();
      first = -1;
      for (int k = 0; k < 70000 && first < 0; k++) begin
         if (tick_o) first = k;
         else step();
      end
      chk("pmax_first", first, 65535);

      // prescale max, period 0
      go(1'b0, 16'd0, 8'd255);
      step();
      first = -1;
      for (int k = 0; k < 600 && first < 0; k++) begin
         if (tick_o) first = k;
         else step();
      end
      chk("psmax_first", first, 255);
      step();
      chk("psmax_gap", tick_o, 0);

      // async reset mid-RUN
      go(1'b0, 16'd9, 8'd0);
      step(); step();
      chk("rr_busy_pre", busy_o, 1);
      #2 rstn_i = 1'b0;
      #1;
      chk("rr_busy", busy_o, 0);
      chk("rr_en", cnt_enable_o, 0);
      chk("rr_cnt", count_i, 0);
      rstn_i = 1'b1;
      step();
      chk("rr_idle", busy_o, 0);

      // async reset while DONE clears done_o
      go(1'b1, 16'd0, 8'd0);
      step();
      chk("od_tick", tick_o, 1);
      step();
      chk("od_done", done_o, 1);
      #2 rstn_i = 1'b0;
      #1;
      chk("od_rst_done", done_o, 0);
      rstn_i = 1'b1;
      step();
      chk("od_after", done_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
